branch_redirect: RTL and testbench

//  Execute-side end of the fetch redirect interface. It takes decoded control-flow

---
 rtl/branch_redirect.sv | 178 +++++++++++++++++
 tb/tb_branch_redirect.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect.sv
// Execute-side branch resolver: decodes control flow, computes targets, and issues a
// registered redirect pulse, a kill window for wrong-path squash, and the R7 link write.
module branch_redirect #(
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_idix_p1,
  input  logic [15:0]      inst_idix_p1,
  input  logic [15:0]      pc_idix_p1,
  input  logic [15:0]      rs_val_idix_p1,
  output logic             branch_taken_ixif_p1,
  output logic [15:0]      branch_target_ixif_p1,
  output logic             kill_p1,
  output logic             link_wr_p1,
  output logic [15:0]      link_data_p1,
  output logic             err_p1,
  output logic [CNT_W-1:0] taken_cnt_p1
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [4:0] OP_BEQZ = 5'b01100;
  localparam logic [4:0] OP_BNEZ = 5'b01101;
  localparam logic [4:0] OP_BLTZ = 5'b01110;
  localparam logic [4:0] OP_BGEZ = 5'b01111;
  localparam logic [4:0] OP_J    = 5'b00100;
  localparam logic [4:0] OP_JR   = 5'b00101;
  localparam logic [4:0] OP_JAL  = 5'b00110;
  localparam logic [4:0] OP_JALR = 5'b00111;

  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic [3:0]       flush_cnt_r, flush_cnt_s;
  logic             taken_s, kill_s, link_wr_s, err_s;
  logic [15:0]      target_s, link_data_s;
  logic [CNT_W-1:0] taken_cnt_s;

  logic [4:0]  opcode_s;
  logic [15:0] sext8_s, sext11_s, pc_plus2_s, calc_target_s;
  logic        is_taken_s, is_link_s, accept_s;

  assign opcode_s   = inst_idix_p1[15:11];
  assign sext8_s    = {{8{inst_idix_p1[7]}}, inst_idix_p1[7:0]};
  assign sext11_s   = {{5{inst_idix_p1[10]}}, inst_idix_p1[10:0]};
  assign pc_plus2_s = pc_idix_p1 + 16'd2;
  assign accept_s   = valid_idix_p1 && (state_r == IDLE) && !kill_p1;

  // Decode direction, target and link for the instruction on the inputs
  always_comb begin
    is_taken_s    = 1'b0;
    is_link_s     = 1'b0;
    calc_target_s = 16'h0000;
    case (opcode_s)
      OP_BEQZ: begin
        is_taken_s    = (rs_val_idix_p1 == 16'h0000);
        calc_target_s = pc_plus2_s + sext8_s;
      end
      OP_BNEZ: begin
        is_taken_s    = (rs_val_idix_p1 != 16'h0000);
        calc_target_s = pc_plus2_s + sext8_s;
      end
      OP_BLTZ: begin
        is_taken_s    = rs_val_idix_p1[15];
        calc_target_s = pc_plus2_s + sext8_s;
      end
      OP_BGEZ: begin
        is_taken_s    = !rs_val_idix_p1[15];
        calc_target_s = pc_plus2_s + sext8_s;
      end
      OP_J: begin
        is_taken_s    = 1'b1;
        calc_target_s = pc_plus2_s + sext11_s;
      end
      OP_JAL: begin
        is_taken_s    = 1'b1;
        is_link_s     = 1'b1;
        calc_target_s = pc_plus2_s + sext11_s;
      end
      OP_JR: begin
        is_taken_s    = 1'b1;
        calc_target_s = rs_val_idix_p1 + sext8_s;
      end
      OP_JALR: begin
        is_taken_s    = 1'b1;
        is_link_s     = 1'b1;
        calc_target_s = rs_val_idix_p1 + sext8_s;
      end
      default: begin
        is_taken_s    = 1'b0;
        is_link_s     = 1'b0;
        calc_target_s = 16'h0000;
      end
    endcase
  end

  // Next-state and next-output logic; outputs are flopped so fetch sees clean pulses
  always_comb begin
    state_s     = state_r;
    flush_cnt_s = flush_cnt_r;
    taken_s     = 1'b0;
    target_s    = 16'h0000;
    kill_s      = 1'b0;
    link_wr_s   = 1'b0;
    link_data_s = 16'h0000;
    err_s       = 1'b0;
    taken_cnt_s = taken_cnt_p1;
    case (state_r)
      IDLE: begin
        if (accept_s && is_taken_s) begin
          if (calc_target_s[0]) begin
            err_s = 1'b1;
          end else begin
            state_s     = REDIRECT;
            taken_s     = 1'b1;
            target_s    = calc_target_s;
            kill_s      = 1'b1;
            link_wr_s   = is_link_s;
            link_data_s = is_link_s ? pc_plus2_s : 16'h0000;
            taken_cnt_s = taken_cnt_p1 + CNT_ONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REDIRECT: begin
        state_s     = FLUSH;
        flush_cnt_s = FLUSH_LOAD;
        kill_s      = 1'b1;
      end
      FLUSH: begin
        // kill stays up while the counter is non-zero, so the window is FLUSH_DEPTH cycles
        if (flush_cnt_r == 4'd0) begin
          state_s = IDLE;
        end else begin
          flush_cnt_s = flush_cnt_r - 4'd1;
          kill_s      = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r               <= IDLE;
      flush_cnt_r           <= 4'd0;
      branch_taken_ixif_p1  <= 1'b0;
      branch_target_ixif_p1 <= 16'h0000;
      kill_p1               <= 1'b0;
      link_wr_p1            <= 1'b0;
      link_data_p1          <= 16'h0000;
      err_p1                <= 1'b0;
      taken_cnt_p1          <= {CNT_W{1'b0}};
    end else begin
      state_r               <= state_s;
      flush_cnt_r           <= flush_cnt_s;
      branch_taken_ixif_p1  <= taken_s;
      branch_target_ixif_p1 <= target_s;
      kill_p1               <= kill_s;
      link_wr_p1            <= link_wr_s;
      link_data_p1          <= link_data_s;
      err_p1                <= err_s;
      taken_cnt_p1          <= taken_cnt_s;
    end
  end

endmodule

// File: tb/tb_branch_redirect.sv
// Directed bench for branch_redirect (FLUSH_DEPTH=2, CNT_W=4) with hand-computed expectations.
module tb_branch_redirect;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [15:0] inst;
  logic [15:0] pc;
  logic [15:0] rs_val;
  logic        taken;
  logic [15:0] target;
  logic        kill;
  logic        link_wr;
  logic [15:0] link_data;
  logic        err;
  logic [3:0]  cnt;

  int tests_run;
  int tests_failed;
  int exp_cnt;

  branch_redirect #(.FLUSH_DEPTH(2), .CNT_W(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .valid_idix_p1        (valid),
    .inst_idix_p1         (inst),
    .pc_idix_p1           (pc),
    .rs_val_idix_p1       (rs_val),
    .branch_taken_ixif_p1 (taken),
    .branch_target_ixif_p1(target),
    .kill_p1              (kill),
    .link_wr_p1           (link_wr),
    .link_data_p1         (link_data),
    .err_p1               (err),
    .taken_cnt_p1         (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] i, input logic [15:0] p,
                       input logic [15:0] r);
    valid  = v;
    inst   = i;
    pc     = p;
    rs_val = r;
  endtask

  // Check one full cycle of outputs
  task automatic chk_all(input string tag, input logic t, input logic [15:0] tg,
                         input logic k, input logic lw, input logic [15:0] ld,
                         input logic e);
    chk({tag, ".taken"},  {31'd0, taken},  {31'd0, t});
    chk({tag, ".target"}, {16'd0, target}, {16'd0, tg});
    chk({tag, ".kill"},   {31'd0, kill},   {31'd0, k});
    chk({tag, ".link_wr"},{31'd0, link_wr},{31'd0, lw});
    chk({tag, ".link"},   {16'd0, link_data}, {16'd0, ld});
    chk({tag, ".err"},    {31'd0, err},    {31'd0, e});
    chk({tag, ".cnt"},    {28'd0, cnt},    exp_cnt[31:0] & 32'hF);
  endtask

  // One redirect pulse followed by the two FLUSH cycles and the return to IDLE
  task automatic drain(input string tag);
    drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
    step(); chk_all({tag, ".f1"}, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
    step(); chk_all({tag, ".f2"}, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
    step(); chk_all({tag, ".idle"}, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_cnt      = 0;
    rst          = 1'b1;
    drive(1'b1, 16'h6004, 16'h0010, 16'h0000);

    // Reset held two cycles with a live BEQZ on the inputs
    step(); chk_all("rst1", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    step(); chk_all("rst2", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    rst = 1'b0;

    // BEQZ pc=0x0010 imm=4 -> 0x0016
    step(); exp_cnt = 1;
    chk_all("beqz", 1'b1, 16'h0016, 1'b1, 1'b0, 16'h0000, 1'b0);
    drain("beqz");

    // BNEZ rs=0 is not taken
    drive(1'b1, 16'h6800, 16'h0030, 16'h0000);
    step(); chk_all("bnez_nt", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);

    // BLTZ rs=0x8000 pc=0x0100 imm=-2 -> 0x0100
    drive(1'b1, 16'h70FE, 16'h0100, 16'h8000);
    step(); exp_cnt = 2;
    chk_all("bltz", 1'b1, 16'h0100, 1'b1, 1'b0, 16'h0000, 1'b0);
    drain("bltz");

    // Misaligned JAL -> err pulse only
    drive(1'b1, 16'h37FF, 16'h0020, 16'h0000);
    step(); chk_all("jal_mis", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
    step(); chk_all("jal_mis_after", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);

    // JALR rs=0x1000 imm=0x10 pc=0x0020 -> 0x1010, link 0x0022
    drive(1'b1, 16'h3810, 16'h0020, 16'h1000);
    step(); exp_cnt = 3;
    chk_all("jalr", 1'b1, 16'h1010, 1'b1, 1'b1, 16'h0022, 1'b0);
    drain("jalr");

    // BEQZ held valid through REDIRECT and FLUSH: only the IDLE offer is taken
    drive(1'b1, 16'h6004, 16'h0010, 16'h0000);
    step(); exp_cnt = 4;
    chk_all("hold_p", 1'b1, 16'h0016, 1'b1, 1'b0, 16'h0000, 1'b0);
    step(); chk_all("hold_f1", 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
    step(); chk_all("hold_f2", 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
    step(); chk_all("hold_idle", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    step(); exp_cnt = 5;
    chk_all("hold_p2", 1'b1, 16'h0016, 1'b1, 1'b0, 16'h0000, 1'b0);

    // rst in the REDIRECT cycle clears everything
    rst = 1'b1;
    drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
    step(); exp_cnt = 0;
    chk_all("rst_mid", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    rst = 1'b0;
    drive(1'b1, 16'h6004, 16'h0010, 16'h0000);
    step(); exp_cnt = 1;
    chk_all("post_rst", 1'b1, 16'h0016, 1'b1, 1'b0, 16'h0000, 1'b0);
    drain("post_rst");

    // J at 0xFFFE with zero displacement wraps to 0x0000
    drive(1'b1, 16'h2000, 16'hFFFE, 16'h0000);
    step(); exp_cnt = 2;
    chk_all("j_wrap", 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
    drain("j_wrap");

    // JR rs=0x0100 imm=4 -> 0x0104
    drive(1'b1, 16'h2804, 16'h0000, 16'h0100);
    step(); exp_cnt = 3;
    chk_all("jr", 1'b1, 16'h0104, 1'b1, 1'b0, 16'h0000, 1'b0);
    drain("jr");

    // BGEZ rs=0x7FFF pc=0x0040 imm=2 -> 0x0044
    drive(1'b1, 16'h7802, 16'h0040, 16'h7FFF);
    step(); exp_cnt = 4;
    chk_all("bgez", 1'b1, 16'h0044, 1'b1, 1'b0, 16'h0000, 1'b0);
    drain("bgez");

    // Unknown opcode is a no-op
    drive(1'b1, 16'hF000, 16'h0040, 16'h0000);
    step(); chk_all("noop", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);

    // JAL targeting its own PC still writes the link
    drive(1'b1, 16'h37FE, 16'h0050, 16'h0000);
    step(); exp_cnt = 5;
    chk_all("jal_self", 1'b1, 16'h0050, 1'b1, 1'b1, 16'h0052, 1'b0);
    drain("jal_self");

    // 16 more redirects take the 4-bit counter through its wrap and back to 5
    for (int n = 0; n < 16; n++) begin
      drive(1'b1, 16'h2002, 16'h0000, 16'h0000);
      step(); exp_cnt = (exp_cnt + 1) % 16;
      chk_all("wrap", 1'b1, 16'h0004, 1'b1, 1'b0, 16'h0000, 1'b0);
      drain("wrap");
    end
    chk("wrap_final", {28'd0, cnt}, 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
